spi_master_ctrl: RTL

SPI master transaction sequencer for the processor's SPI peripheral, in SPI mode 0 (CPOL=0, CPHA=0).
- Receives a burst request (byte count plus per-byte transmit data) from the peripheral register interface.
- Generates `cs_o`, `sclk_o` and `mosi_o`.
- Drives the shift-enable and clear inputs of the serial-in/parallel-out receive register that captures MISO.
- Reports per-byte and end-of-burst completion.

---
 rtl/spi_master_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master burst sequencer: drives CS/SCLK/MOSI, steers an external
// MISO receive shifter, and flags per-byte and end-of-burst completion.
`timescale 1ns/1ps

module spi_master_ctrl #(
  parameter int CLK_DIV = 5,
  parameter int CNT_W   = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_bytes_i,
  input  logic [7:0]       tx_data_i,
  output logic             cs_o,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic             shift_o,
  output logic             rx_clr_o,
  output logic             busy_o,
  output logic             byte_done_o,
  output logic             done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = (CLK_DIV > 1) ? DIV_W'(CLK_DIV - 2) : '0;

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] bytes_left;
  logic [7:0]       tx;

  logic div_end;
  logic enter_last_low;
  logic byte_end;

  assign div_end = (div == DIV_LAST);
  // Byte bookkeeping happens on the edge that enters the final LOW cycle,
  // which for a one-cycle half-period is the HIGH->LOW edge itself.
  assign enter_last_low = (CLK_DIV == 1) ? (state == HIGH && div_end)
                                         : (state == LOW && div == DIV_PRE);
  assign byte_end = enter_last_low && (bit_cnt == 3'd7);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      bytes_left  <= '0;
      tx          <= '0;
      cs_o        <= 1'b1;
      sclk_o      <= 1'b0;
      mosi_o      <= 1'b0;
      shift_o     <= 1'b0;
      rx_clr_o    <= 1'b0;
      busy_o      <= 1'b0;
      byte_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      shift_o     <= 1'b0;
      rx_clr_o    <= 1'b0;
      byte_done_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && n_bytes_i != '0) begin
            state      <= LEAD;
            div        <= '0;
            bit_cnt    <= '0;
            bytes_left <= n_bytes_i;
            tx         <= tx_data_i;
            cs_o       <= 1'b0;
            busy_o     <= 1'b1;
            mosi_o     <= tx_data_i[7];
            rx_clr_o   <= 1'b1;
          end
        end
        LEAD: begin
          if (div_end) begin
            div     <= '0;
            state   <= HIGH;
            sclk_o  <= 1'b1;
            shift_o <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        HIGH: begin
          if (div_end) begin
            div    <= '0;
            state  <= LOW;
            sclk_o <= 1'b0;
            mosi_o <= tx[6];
            tx     <= {tx[6:0], 1'b0};
          end else begin
            div <= div + 1'b1;
          end
        end
        LOW: begin
          if (div_end) begin
            div     <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7 && bytes_left == '0) begin
              state <= TRAIL;
            end else begin
              state   <= HIGH;
              sclk_o  <= 1'b1;
              shift_o <= 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        TRAIL: begin
          if (div_end) begin
            div    <= '0;
            state  <= IDLE;
            cs_o   <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Next byte is loaded here, overriding the plain shift, so SCLK never pauses.
      if (byte_end) begin
        byte_done_o <= 1'b1;
        bytes_left  <= bytes_left - 1'b1;
        if (bytes_left != CNT_W'(1)) begin
          tx     <= tx_data_i;
          mosi_o <= tx_data_i[7];
        end
      end
    end
  end

endmodule
